tri_pipe_sequencer: RTL and testbench

Top-level sequencer for the triangle pipeline. It takes a draw request of N triangles and runs each triangle in turn through three stages: triangle fetch (fetcher `startFetch`/`startCull` handshake), cull decision, and rasterisation. Culled triangles skip rasterisation. It sits between the command/register interface and the fetcher, culler and rasteriser, and is the only block that issues `startFetch`.

---
 rtl/tri_pipe_sequencer.sv | 122 ++++++++++++
 tb/tb_tri_pipe_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tri_pipe_sequencer.sv
// Sequences a draw of N triangles through fetch, cull decision and rasterisation, one triangle at a time.
// Optional TRI_SEQ_STATS_EN adds saturating culled/rastered counters; fetch_start, raster_start, done and busy are registered.
module tri_pipe_sequencer #(
    parameter int TRI_CNT_WIDTH = 16,
    parameter int ADDR_WIDTH    = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     en,
    input  logic                     start,
    input  logic [TRI_CNT_WIDTH-1:0] num_triangles,
    input  logic [ADDR_WIDTH-1:0]    vertex_size_in,
    output logic [ADDR_WIDTH-1:0]    vertex_size,
    output logic                     fetch_start,
    input  logic                     fetch_done,
    input  logic                     cull_valid,
    input  logic                     cull,
    output logic                     raster_start,
    input  logic                     raster_done,
    output logic                     busy,
    output logic                     done,
    output logic [TRI_CNT_WIDTH-1:0] tri_index
`ifdef TRI_SEQ_STATS_EN
    ,
    output logic [TRI_CNT_WIDTH-1:0] stat_culled,
    output logic [TRI_CNT_WIDTH-1:0] stat_rastered
`endif
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_FETCH, WAIT_CULL, RASTER, WAIT_RASTER, NEXT, DONE
    } state_t;

    state_t                   state;
    logic [TRI_CNT_WIDTH-1:0] remaining;

    // Pulse outputs are assigned together with the transition into their state,
    // so they line up exactly with the state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            remaining    <= '0;
            tri_index    <= '0;
            vertex_size  <= '0;
            fetch_start  <= 1'b0;
            raster_start <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else if (en) begin
            fetch_start  <= 1'b0;
            raster_start <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining   <= num_triangles;
                        vertex_size <= vertex_size_in;
                        tri_index   <= '0;
                        busy        <= 1'b1;
                        if (num_triangles == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= ISSUE;
                            fetch_start <= 1'b1;
                        end
                    end
                end
                ISSUE:      state <= WAIT_FETCH;
                WAIT_FETCH: if (fetch_done) state <= WAIT_CULL;
                WAIT_CULL: begin
                    if (cull_valid) begin
                        if (cull) begin
                            state <= NEXT;
                        end else begin
                            state        <= RASTER;
                            raster_start <= 1'b1;
                        end
                    end
                end
                RASTER:      state <= WAIT_RASTER;
                WAIT_RASTER: if (raster_done) state <= NEXT;
                NEXT: begin
                    if (remaining == TRI_CNT_WIDTH'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        remaining   <= remaining - TRI_CNT_WIDTH'(1);
                        tri_index   <= tri_index + TRI_CNT_WIDTH'(1);
                        state       <= ISSUE;
                        fetch_start <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TRI_SEQ_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_culled   <= '0;
            stat_rastered <= '0;
        end else if (en) begin
            if (state == IDLE && start) begin
                stat_culled   <= '0;
                stat_rastered <= '0;
            end else begin
                if (state == WAIT_CULL && cull_valid && cull && stat_culled != '1)
                    stat_culled <= stat_culled + TRI_CNT_WIDTH'(1);
                if (state == WAIT_RASTER && raster_done && stat_rastered != '1)
                    stat_rastered <= stat_rastered + TRI_CNT_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_tri_pipe_sequencer.sv
// Directed bench for tri_pipe_sequencer: a small responder plays fetcher, culler and rasteriser.
module tb_tri_pipe_sequencer;
    localparam int TW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          resetn, en, start, fetch_done, cull_valid, cull, raster_done;
    logic [TW-1:0] num_triangles, tri_index;
    logic [AW-1:0] vertex_size_in, vertex_size;
    logic          fetch_start, raster_start, busy, done;
`ifdef TRI_SEQ_STATS_EN
    logic [TW-1:0] stat_culled, stat_rastered;
`endif

    always #5 clk = ~clk;

    tri_pipe_sequencer #(.TRI_CNT_WIDTH(TW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .resetn(resetn), .en(en), .start(start),
        .num_triangles(num_triangles), .vertex_size_in(vertex_size_in),
        .vertex_size(vertex_size), .fetch_start(fetch_start), .fetch_done(fetch_done),
        .cull_valid(cull_valid), .cull(cull), .raster_start(raster_start),
        .raster_done(raster_done), .busy(busy), .done(done), .tri_index(tri_index)
`ifdef TRI_SEQ_STATS_EN
        , .stat_culled(stat_culled), .stat_rastered(stat_rastered)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_fs = 0, n_rs = 0, n_dn = 0;
    int s_fs, s_rs, s_dn;

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (fetch_start)  n_fs++;
            if (raster_start) n_rs++;
            if (done)         n_dn++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic snap;
        s_fs = n_fs; s_rs = n_rs; s_dn = n_dn;
    endtask

    // sel: 0 fetch_start, 1 raster_start, 2 done
    task automatic wait_hi(input int sel, input string tag);
        int k = 0;
        while (!(sel == 0 ? fetch_start : sel == 1 ? raster_start : done) && k < 60) begin
            step;
            k++;
        end
        chk(tag, {31'd0, (sel == 0 ? fetch_start : sel == 1 ? raster_start : done)}, 32'd1);
    endtask

    task automatic start_draw(input logic [TW-1:0] n, input logic [AW-1:0] vs);
        num_triangles  = n;
        vertex_size_in = vs;
        start = 1'b1;
        step;
        start = 1'b0;
    endtask

    // Plays one triangle from its fetch_start pulse to the NEXT state.
    task automatic run_tri(input int idx, input bit c, input int flat, input int rlat, input bit spur);
        wait_hi(0, "fetch_start_wait");
        chk("tri_index", tri_index, idx);
        step;
        if (spur) begin
            raster_done = 1'b1; step; raster_done = 1'b0;
            chk("spur_rd_raster_start", raster_start, 0);
            chk("spur_rd_busy", busy, 1);
        end
        repeat (flat - 1) step;
        fetch_done = 1'b1; step; fetch_done = 1'b0;
        if (spur) begin
            fetch_done = 1'b1; step; fetch_done = 1'b0;
            chk("spur_fd_raster_start", raster_start, 0);
        end
        cull_valid = 1'b1; cull = c; step; cull_valid = 1'b0; cull = 1'b0;
        if (!c) begin
            chk("raster_start", raster_start, 1);
            step;
            repeat (rlat - 1) step;
            raster_done = 1'b1; step; raster_done = 1'b0;
        end else begin
            chk("culled_no_raster", raster_start, 0);
        end
    endtask

    // Called while in the final NEXT state.
    task automatic finish_draw;
        step;
        chk("done_pulse", done, 1);
        chk("busy_in_done", busy, 1);
        step;
        chk("done_clear", done, 0);
        chk("busy_clear", busy, 0);
    endtask

    initial begin
        resetn = 1'b0; en = 1'b1; start = 1'b0; fetch_done = 1'b0; cull_valid = 1'b0;
        cull = 1'b0; raster_done = 1'b0; num_triangles = '0; vertex_size_in = '0;
        repeat (2) step;
        chk("rst_fetch_start", fetch_start, 0);
        chk("rst_raster_start", raster_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tri_index", tri_index, 0);
        chk("rst_vertex_size", vertex_size, 0);
        resetn = 1'b1;
        step;

        // 3 triangles, none culled, 5-cycle fetch/raster, spurious inputs and restart attempt
        snap;
        start_draw(3, 5);
        chk("a_fetch_start_k1", fetch_start, 1);
        chk("a_busy_k1", busy, 1);
        chk("a_vertex_size", vertex_size, 5);
        run_tri(0, 1'b0, 5, 5, 1'b1);
        vertex_size_in = 9; num_triangles = 7; start = 1'b1;
        step;
        start = 1'b0;
        chk("a_vs_held", vertex_size, 5);
        run_tri(1, 1'b0, 5, 5, 1'b0);
        run_tri(2, 1'b0, 5, 5, 1'b0);
        finish_draw;
        chk("a_tri_index_end", tri_index, 2);
        step;
        chk("a_fetch_cnt", n_fs - s_fs, 3);
        chk("a_raster_cnt", n_rs - s_rs, 3);
        chk("a_done_cnt", n_dn - s_dn, 1);

        // 4 triangles, indices 1 and 3 culled
        snap;
        start_draw(4, 3);
        run_tri(0, 1'b0, 2, 3, 1'b0);
        run_tri(1, 1'b1, 1, 1, 1'b0);
        run_tri(2, 1'b0, 3, 1, 1'b0);
        run_tri(3, 1'b1, 2, 1, 1'b0);
        finish_draw;
        step;
        chk("b_fetch_cnt", n_fs - s_fs, 4);
        chk("b_raster_cnt", n_rs - s_rs, 2);
        chk("b_done_cnt", n_dn - s_dn, 1);
`ifdef TRI_SEQ_STATS_EN
        chk("b_stat_culled", stat_culled, 2);
        chk("b_stat_rastered", stat_rastered, 2);
`endif

        // Empty draw goes straight to DONE
        snap;
        start_draw(0, 2);
        chk("c_done", done, 1);
        chk("c_fetch_start", fetch_start, 0);
        step;
        chk("c_done_clear", done, 0);
        chk("c_busy_clear", busy, 0);
        step;
        chk("c_fetch_cnt", n_fs - s_fs, 0);
        chk("c_raster_cnt", n_rs - s_rs, 0);
        chk("c_done_cnt", n_dn - s_dn, 1);
        chk("c_vertex_size", vertex_size, 2);

        // en low for 10 cycles in WAIT_FETCH; fetch_done during the freeze is lost
        snap;
        start_draw(1, 4);
        wait_hi(0, "d_fetch_start_wait");
        step;
        en = 1'b0;
        fetch_done = 1'b1; step; fetch_done = 1'b0;
        repeat (9) step;
        chk("d_frozen_busy", busy, 1);
        en = 1'b1;
        repeat (3) step;
        chk("d_still_busy", busy, 1);
        chk("d_no_raster", raster_start, 0);
        fetch_done = 1'b1; step; fetch_done = 1'b0;
        cull_valid = 1'b1; step; cull_valid = 1'b0;
        chk("d_raster_start", raster_start, 1);
        step;
        raster_done = 1'b1; step; raster_done = 1'b0;
        finish_draw;
        step;
        chk("d_done_cnt", n_dn - s_dn, 1);

        // Reset in WAIT_RASTER of triangle 2, then a fresh draw
        snap;
        start_draw(4, 6);
        run_tri(0, 1'b0, 2, 2, 1'b0);
        run_tri(1, 1'b0, 2, 2, 1'b0);
        wait_hi(0, "e_fetch_start_wait");
        chk("e_tri_index", tri_index, 2);
        step;
        fetch_done = 1'b1; step; fetch_done = 1'b0;
        cull_valid = 1'b1; step; cull_valid = 1'b0;
        chk("e_raster_start", raster_start, 1);
        step;
        #2 resetn = 1'b0;
        #1;
        chk("e_rst_busy", busy, 0);
        chk("e_rst_tri_index", tri_index, 0);
        chk("e_rst_vertex_size", vertex_size, 0);
        chk("e_rst_raster_start", raster_start, 0);
        chk("e_rst_done", done, 0);
        repeat (3) step;
        resetn = 1'b1;
        step;
        chk("e_no_done", n_dn - s_dn, 0);
        start_draw(1, 7);
        chk("e_restart_fetch", fetch_start, 1);
        chk("e_restart_vs", vertex_size, 7);
        run_tri(0, 1'b0, 2, 2, 1'b0);
        finish_draw;
        step;
        chk("e_done_cnt", n_dn - s_dn, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
